// File: rtl/branch_predict_unit.sv
// Branch resolution from ALU flags plus a BHT of saturating counters.
// Fetch reads the table combinationally; EX trains it and the performance counters on the clock edge.
`timescale 1ns/1ps
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   fetch_pc,
  output logic              predict_taken,
  input  logic              Branch,
  input  logic              stall,
  input  logic [3:0]        Flags,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic              ex_pred_taken,
  output logic              taken,
  output logic              mispredict,
  output logic [PERF_W-1:0] branch_count,
  output logic [PERF_W-1:0] mispredict_count
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  // Weakly-not-taken: all ones shifted down gives 2^(CTR_BITS-1)-1, and 0 for CTR_BITS=1.
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;

  logic [CTR_BITS-1:0] r_bht [BHT_ENTRIES];
  logic [PERF_W-1:0]   r_branch_count;
  logic [PERF_W-1:0]   r_mispredict_count;

  logic [IDX_W-1:0] w_fetch_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic             w_cond;
  logic             w_update;
  logic             w_v, w_c, w_n, w_z;
  logic             w_unused;

  assign w_fetch_idx = fetch_pc[IDX_W+1:2];
  assign w_ex_idx    = ex_pc[IDX_W+1:2];
  assign {w_v, w_c, w_n, w_z} = Flags;
  assign w_unused    = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                         ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  always_comb begin
    w_cond = 1'b0;
    case (funct3)
      3'b000:  w_cond = w_z;
      3'b001:  w_cond = ~w_z;
      3'b100:  w_cond = w_n ^ w_v;
      3'b101:  w_cond = ~(w_n ^ w_v);
      3'b110:  w_cond = ~w_c;
      3'b111:  w_cond = w_c;
      default: w_cond = 1'b0;
    endcase
  end

  assign taken         = w_cond & Branch;
  assign mispredict    = Branch & (taken != ex_pred_taken);
  assign w_update      = Branch & ~stall;
  assign predict_taken = ~reset & r_bht[w_fetch_idx][CTR_BITS-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= CTR_INIT;
    end else if (w_update) begin
      if (taken && r_bht[w_ex_idx] != CTR_MAX)
        r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 1'b1;
      else if (!taken && r_bht[w_ex_idx] != '0)
        r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (w_update) begin
      if (!(&r_branch_count))
        r_branch_count <= r_branch_count + 1'b1;
      if (mispredict && !(&r_mispredict_count))
        r_mispredict_count <= r_mispredict_count + 1'b1;
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: driver pushes expected responses from a reference model,
// a negedge monitor pops and compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_branch_predict_unit;
  localparam int XLEN = 32;
  localparam int N    = 64;
  localparam int CB   = 2;
  localparam int PW   = 4;
  localparam int CMAX = (1 << CB) - 1;
  localparam int PMAX = (1 << PW) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [XLEN-1:0] fetch_pc = '0;
  logic            predict_taken;
  logic            Branch = 1'b0;
  logic            stall = 1'b0;
  logic [3:0]      Flags = '0;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] ex_pc = '0;
  logic            ex_pred_taken = 1'b0;
  logic            taken;
  logic            mispredict;
  logic [PW-1:0]   branch_count;
  logic [PW-1:0]   mispredict_count;

  branch_predict_unit #(.XLEN(XLEN), .BHT_ENTRIES(N), .CTR_BITS(CB), .PERF_W(PW)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .predict_taken(predict_taken),
    .Branch(Branch), .stall(stall), .Flags(Flags), .funct3(funct3), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .taken(taken), .mispredict(mispredict),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer counters per table slot.
  int bht [N];
  int bc, mc;
  int tests = 0;
  int fails = 0;

  // Packed expectation: {predict_taken, taken, mispredict, branch_count, mispredict_count}
  localparam int W = 3 + 2 * PW;
  logic [W-1:0] exp_q[$];

  function automatic int idx_of(input logic [XLEN-1:0] pc);
    return (pc / 4) % N;
  endfunction

  function automatic bit cond_of(input logic [2:0] f3, input logic [3:0] fl);
    bit v, c, n, z;
    {v, c, n, z} = fl;
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return n != v;
      3'd5: return n == v;
      3'd6: return !c;
      3'd7: return c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit model_pred(input logic [XLEN-1:0] pc);
    return bht[idx_of(pc)] >= (CMAX + 1) / 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) bht[i] = (CMAX + 1) / 2 - 1;
    bc = 0;
    mc = 0;
  endtask

  // One cycle: apply inputs just after a rising edge, queue the expectation, then advance.
  task automatic drive(input bit r, input bit br, input bit st, input logic [3:0] fl,
                       input logic [2:0] f3, input logic [XLEN-1:0] epc, input bit ep,
                       input logic [XLEN-1:0] fpc);
    bit t, m, pt;
    int k;
    reset = r; Branch = br; stall = st; Flags = fl; funct3 = f3;
    ex_pc = epc; ex_pred_taken = ep; fetch_pc = fpc;
    if (r) model_reset();
    t  = br && cond_of(f3, fl);
    m  = br && (t != ep);
    pt = !r && model_pred(fpc);
    exp_q.push_back({pt, t, m, PW'(bc), PW'(mc)});
    @(posedge clk);
    if (!r && br && !st) begin
      k = idx_of(epc);
      if (t && bht[k] < CMAX) bht[k]++;
      else if (!t && bht[k] > 0) bht[k]--;
      if (bc < PMAX) bc++;
      if (m && mc < PMAX) mc++;
    end
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      chk("predict_taken", int'(predict_taken), int'(e[W-1]));
      chk("taken", int'(taken), int'(e[W-2]));
      chk("mispredict", int'(mispredict), int'(e[W-3]));
      chk("branch_count", int'(branch_count), int'(e[2*PW-1:PW]));
      chk("mispredict_count", int'(mispredict_count), int'(e[PW-1:0]));
    end
  end

  initial begin
    logic [XLEN-1:0] epc, fpc;
    logic [2:0] f3;
    bit ep;
    model_reset();
    @(posedge clk); #1;
    // Reset state
    drive(1, 0, 0, 4'h0, 3'd0, 32'h100, 0, 32'h100);
    drive(0, 0, 0, 4'h0, 3'd0, 32'h100, 0, 32'h100);
    // Same-PC training: taken until saturation, then two not-taken
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 4'h1, 3'd0, 32'h100, 0, 32'h100);
    drive(0, 1, 0, 4'h0, 3'd0, 32'h100, 1, 32'h100);
    drive(0, 1, 0, 4'h0, 3'd0, 32'h100, 1, 32'h100);
    drive(0, 0, 0, 4'h0, 3'd0, 32'h100, 0, 32'h100);
    // Flag decode sweep with v=1, including invalid codes
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 4'b1000, 3'(i), 32'h40, 0, 32'h40);
    // Stall holds state; one update after release
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 4'h1, 3'd0, 32'h200, 0, 32'h200);
    drive(0, 1, 0, 4'h1, 3'd0, 32'h200, 0, 32'h200);
    drive(0, 0, 0, 4'h0, 3'd0, 32'h200, 0, 32'h200);
    // Aliasing 0x000 vs 0x100, and same-cycle read/write shows old value
    drive(0, 1, 0, 4'h1, 3'd0, 32'h000, 0, 32'h100);
    drive(0, 1, 0, 4'h1, 3'd0, 32'h300, 0, 32'h300);
    drive(0, 0, 0, 4'h0, 3'd0, 32'h000, 0, 32'h300);
    // Counter saturation, then reset mid-stream
    for (int i = 0; i < 20; i++) drive(0, 1, 0, 4'($urandom), 3'($urandom), 32'h80, 0, 32'h80);
    drive(1, 1, 0, 4'h1, 3'd0, 32'h80, 0, 32'h100);
    drive(1, 1, 0, 4'h1, 3'd0, 32'h80, 0, 32'h80);
    drive(0, 0, 0, 4'h0, 3'd0, 32'h80, 0, 32'h80);
    // Randomized traffic over a small PC set so entries train and alias
    for (int i = 0; i < 400; i++) begin
      epc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      fpc = ($urandom_range(0, 1) == 1) ? epc
          : (($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2));
      f3  = 3'($urandom);
      ep  = ($urandom_range(0, 3) == 0) ? 1'($urandom) : model_pred(epc);
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            4'($urandom), f3, epc, ep, fpc);
    end
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
